// File: rtl/updown_counter_mod_if.sv
// Control/status bundle for updown_counter_mod: the master drives the count controls,
// the slave (the counter) returns the count and its status flags.
interface updown_counter_mod_if #(
  parameter int unsigned WIDTH = 10
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             en;
  logic             updn;
  logic [WIDTH-1:0] cmp_val;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             ovf;
  logic             cmp_hit;
  logic             at_min;
  logic             at_max;

  modport master (
    output clr, load, data_in, en, updn, cmp_val,
    input  cnt, tc, ovf, cmp_hit, at_min, at_max
  );

  modport slave (
    input  clr, load, data_in, en, updn, cmp_val,
    output cnt, tc, ovf, cmp_hit, at_min, at_max
  );
endinterface

// File: rtl/updown_counter_mod.sv
// Modulo up/down counter (0..MAX_VAL) with sync clear/load, prescaled enable,
// wrap or saturate at the boundaries, terminal-count pulse and sticky boundary flag.
module updown_counter_mod #(
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned MAX_VAL = 1595,
  parameter int unsigned PRESC   = 1,
  parameter int unsigned SAT     = 0
) (
  input  logic                 clk5m,
  input  logic                 rst_n,
  updown_counter_mod_if.slave  bus
);

  // A MAX_VAL that does not fit in WIDTH bits falls back to the full WIDTH-bit range.
  localparam logic [WIDTH-1:0] MaxVal =
      (MAX_VAL > (2 ** WIDTH) - 1) ? {WIDTH{1'b1}} : WIDTH'(MAX_VAL);
  localparam bit Saturate = (SAT != 0);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             tick;

  if (PRESC > 1) begin : g_presc
    localparam int unsigned PW = $clog2(PRESC);
    localparam logic [PW-1:0] PrescLast = PW'(PRESC - 1);

    logic [PW-1:0] presc_q, presc_d;

    assign tick = bus.en && (presc_q == PrescLast);

    always_comb begin
      presc_d = presc_q;
      if (bus.clr || bus.load) begin
        presc_d = '0;
      end else if (bus.en) begin
        presc_d = (presc_q == PrescLast) ? '0 : presc_q + 1'b1;
      end
    end

    always_ff @(posedge clk5m or negedge rst_n) begin
      if (!rst_n) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_d;
      end
    end
  end else begin : g_no_presc
    assign tick = bus.en;
  end

  // Boundary is tested before the add/subtract so a MaxVal below the natural
  // 2^WIDTH-1 rollover still wraps correctly.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (bus.clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (bus.load) begin
      cnt_d = (bus.data_in > MaxVal) ? MaxVal : bus.data_in;
    end else if (tick) begin
      if (!bus.updn) begin
        if (cnt_q == MaxVal) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          if (!Saturate) cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q == '0) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          if (!Saturate) cnt_d = MaxVal;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk5m or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.cnt     = cnt_q;
  assign bus.tc      = tc_q;
  assign bus.ovf     = ovf_q;
  assign bus.cmp_hit = (cnt_q == bus.cmp_val);
  assign bus.at_min  = (cnt_q == '0);
  assign bus.at_max  = (cnt_q == MaxVal);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Scoreboard bench: three counter configurations share one stimulus stream; a
// reference model predicts each cycle's outputs and a monitor compares them.
module tb_updown_counter_mod;

  localparam int unsigned W = 11;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         tc;
    logic         ovf;
    logic         hit;
    logic         amin;
    logic         amax;
  } obs_t;
  typedef obs_t [2:0] trio_t;

  logic clk5m = 1'b0;
  logic rst_n = 1'b0;

  logic         clr = 1'b0, load = 1'b0, en = 1'b0, updn = 1'b0;
  logic [W-1:0] data_in = '0, cmp_val = '1;

  int checks   = 0;
  int failures = 0;

  trio_t sb[$];

  // Reference model state, one slot per instance.
  int m_cnt [3];
  int m_ph  [3];
  bit m_ovf [3];
  bit m_tc  [3];

  updown_counter_mod_if #(.WIDTH(W)) if0 ();
  updown_counter_mod_if #(.WIDTH(W)) if1 ();
  updown_counter_mod_if #(.WIDTH(W)) if2 ();

  assign if0.clr = clr;  assign if0.load = load; assign if0.data_in = data_in;
  assign if0.en  = en;   assign if0.updn = updn; assign if0.cmp_val = cmp_val;
  assign if1.clr = clr;  assign if1.load = load; assign if1.data_in = data_in;
  assign if1.en  = en;   assign if1.updn = updn; assign if1.cmp_val = cmp_val;
  assign if2.clr = clr;  assign if2.load = load; assign if2.data_in = data_in;
  assign if2.en  = en;   assign if2.updn = updn; assign if2.cmp_val = cmp_val;

  updown_counter_mod #(.WIDTH(W), .MAX_VAL(1595), .PRESC(1), .SAT(0)) u_wrap (
    .clk5m (clk5m),
    .rst_n (rst_n),
    .bus   (if0)
  );
  updown_counter_mod #(.WIDTH(W), .MAX_VAL(1595), .PRESC(1), .SAT(1)) u_sat (
    .clk5m (clk5m),
    .rst_n (rst_n),
    .bus   (if1)
  );
  updown_counter_mod #(.WIDTH(W), .MAX_VAL(100), .PRESC(4), .SAT(0)) u_presc (
    .clk5m (clk5m),
    .rst_n (rst_n),
    .bus   (if2)
  );

  always #10 clk5m = ~clk5m;

  function automatic int max_of(input int i);
    return (i == 2) ? 100 : 1595;
  endfunction
  function automatic int presc_of(input int i);
    return (i == 2) ? 4 : 1;
  endfunction
  function automatic bit sat_of(input int i);
    return (i == 1);
  endfunction

  function automatic obs_t actual(input int i);
    obs_t o;
    case (i)
      0:       o = '{if0.cnt, if0.tc, if0.ovf, if0.cmp_hit, if0.at_min, if0.at_max};
      1:       o = '{if1.cnt, if1.tc, if1.ovf, if1.cmp_hit, if1.at_min, if1.at_max};
      default: o = '{if2.cnt, if2.tc, if2.ovf, if2.cmp_hit, if2.at_min, if2.at_max};
    endcase
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_ph[i] = 0; m_ovf[i] = 1'b0; m_tc[i] = 1'b0;
    end
  endtask

  // One clock edge of behaviour for every instance, straight from the counting rules.
  task automatic model_step(output trio_t t);
    for (int i = 0; i < 3; i++) begin
      int mx;
      bit tick;
      bit edge_hit;
      mx = max_of(i);
      tick = 1'b0;
      m_tc[i] = 1'b0;
      if (clr) begin
        m_cnt[i] = 0; m_ovf[i] = 1'b0; m_ph[i] = 0;
      end else if (load) begin
        m_cnt[i] = (int'(data_in) > mx) ? mx : int'(data_in);
        m_ph[i]  = 0;
      end else if (en) begin
        m_ph[i] = m_ph[i] + 1;
        if (m_ph[i] == presc_of(i)) begin
          m_ph[i] = 0;
          tick = 1'b1;
        end
      end
      if (tick) begin
        edge_hit = updn ? (m_cnt[i] == 0) : (m_cnt[i] == mx);
        if (edge_hit) begin
          m_tc[i]  = 1'b1;
          m_ovf[i] = 1'b1;
          if (!sat_of(i)) m_cnt[i] = updn ? mx : 0;
        end else begin
          m_cnt[i] = updn ? m_cnt[i] - 1 : m_cnt[i] + 1;
        end
      end
      t[i].cnt  = W'(m_cnt[i]);
      t[i].tc   = m_tc[i];
      t[i].ovf  = m_ovf[i];
      t[i].hit  = (m_cnt[i] == int'(cmp_val));
      t[i].amin = (m_cnt[i] == 0);
      t[i].amax = (m_cnt[i] == mx);
    end
  endtask

  task automatic cycle(input bit c, input bit l, input int d, input bit e, input bit u,
                       input int cv);
    trio_t t;
    @(negedge clk5m);
    clr = c; load = l; data_in = W'(d); en = e; updn = u; cmp_val = W'(cv);
    model_step(t);
    sb.push_back(t);
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic settle();
    @(posedge clk5m);
    #2;
  endtask

  // Monitor: every edge with a pending prediction is compared per instance.
  initial begin
    trio_t exp;
    obs_t  act;
    forever begin
      @(posedge clk5m);
      #1;
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
          act = actual(i);
          checks++;
          if (act !== exp[i]) begin
            failures++;
            $display("FAIL sb[%0d] t=%0t: got cnt=%0d tc=%b ovf=%b hit=%b min=%b max=%b expected cnt=%0d tc=%b ovf=%b hit=%b min=%b max=%b",
                     i, $time, act.cnt, act.tc, act.ovf, act.hit, act.amin, act.amax,
                     exp[i].cnt, exp[i].tc, exp[i].ovf, exp[i].hit, exp[i].amin,
                     exp[i].amax);
          end
        end
      end
    end
  end

  initial begin
    int cv;
    bit dir;
    model_reset();
    #5;
    for (int i = 0; i < 3; i++) begin
      obs_t a;
      a = actual(i);
      check_val($sformatf("reset_cnt%0d", i), int'(a.cnt), 0);
      check_val($sformatf("reset_tc%0d", i), int'(a.tc), 0);
      check_val($sformatf("reset_ovf%0d", i), int'(a.ovf), 0);
    end
    #28 rst_n = 1'b1;

    // Load and clamp.
    cycle(0, 1, 500, 0, 0, 2047);
    settle();
    check_val("load_500", int'(if0.cnt), 500);
    cycle(0, 1, 2047, 0, 0, 2047);
    settle();
    check_val("load_clamp_wrap", int'(if0.cnt), 1595);
    check_val("load_clamp_presc", int'(if2.cnt), 100);

    // Up through the wrap boundary with cmp_val at 0.
    cycle(0, 1, 1594, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0, 2047);
    settle();
    check_val("ovf_sticky", int'(if0.ovf), 1);
    cycle(1, 0, 0, 0, 0, 2047);

    // Down into the lower boundary.
    cycle(0, 1, 2, 0, 1, 2047);
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, 1, 2047);
    settle();
    check_val("sat_hold_zero", int'(if1.cnt), 0);
    check_val("sat_tc_repeat", int'(if1.tc), 1);

    // Prescaler: 12 enabled cycles give three steps.
    cycle(0, 1, 10, 0, 0, 2047);
    for (int k = 0; k < 12; k++) cycle(0, 0, 0, 1, 0, 2047);
    settle();
    check_val("presc_12", int'(if2.cnt), 13);
    cycle(0, 1, 10, 0, 0, 2047);
    cycle(0, 0, 0, 1, 0, 2047);
    cycle(0, 0, 0, 1, 0, 2047);
    cycle(0, 0, 0, 0, 0, 2047);
    cycle(0, 0, 0, 0, 0, 2047);
    cycle(0, 0, 0, 1, 0, 2047);
    settle();
    check_val("presc_gap_wait", int'(if2.cnt), 10);
    cycle(0, 0, 0, 1, 0, 2047);
    settle();
    check_val("presc_gap_step", int'(if2.cnt), 11);

    // Priority: clr beats load and step; load beats step.
    cycle(0, 1, 700, 0, 0, 2047);
    cycle(1, 1, 55, 1, 0, 2047);
    cycle(0, 1, 42, 1, 0, 2047);
    settle();
    check_val("load_over_step", int'(if0.cnt), 42);

    // Asynchronous reset between edges.
    cycle(0, 1, 300, 0, 0, 2047);
    settle();
    #1 rst_n = 1'b0;
    #1;
    check_val("async_cnt", int'(if0.cnt), 0);
    check_val("async_cnt_sat", int'(if1.cnt), 0);
    check_val("async_ovf", int'(if0.ovf), 0);
    model_reset();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 0, 2);

    // Randomised traffic.
    dir = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      cv = ($urandom_range(0, 3) == 0) ? m_cnt[0] + 1 : int'($urandom_range(0, 2047));
      cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 4),
            int'($urandom_range(0, 2047)), ($urandom_range(0, 9) < 8), dir, cv);
    end
    cycle(0, 0, 0, 0, 0, 2047);
    settle();
    check_val("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
